// File: rtl/btb_pkg.sv
// Shared types and helpers for the associative BTB: 2-bit direction counter
// encodings and their saturating step functions.
package btb_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RST = WNT;

  function automatic ctr_e sat_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'b01);
  endfunction

  function automatic ctr_e sat_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'b01);
  endfunction

endpackage

// File: rtl/btb_entry.sv
// One BTB row: tag/target storage, IF and EX tag compares, direction counter
// and saturating age. Write strobes come pre-decoded from the top.
module btb_entry
  import btb_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned AGE_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             upd_i,
  input  logic             alloc_i,
  input  logic             age_inc_i,
  input  logic             taken_i,
  input  logic [PC_W-1:0]  if_pc_i,
  input  logic [PC_W-1:0]  ex_pc_i,
  input  logic [PC_W-1:0]  des_i,
  output logic             valid_o,
  output logic             if_hit_o,
  output logic             ex_hit_o,
  output logic             pred_o,
  output logic [PC_W-1:0]  target_o,
  output logic [AGE_W-1:0] age_o
);

  logic             valid_q, valid_d;
  logic [PC_W-1:0]  tag_q, tag_d;
  logic [PC_W-1:0]  tgt_q, tgt_d;
  ctr_e             ctr_q, ctr_d;
  logic [AGE_W-1:0] age_q, age_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    age_d   = age_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (alloc_i) begin
      valid_d = 1'b1;
      tag_d   = ex_pc_i;
      tgt_d   = des_i;
      ctr_d   = taken_i ? WT : WNT;
      age_d   = '0;
    end else if (upd_i) begin
      ctr_d = taken_i ? sat_inc(ctr_q) : sat_dec(ctr_q);
      if (taken_i) tgt_d = des_i;
      age_d = '0;
    end else if (age_inc_i && valid_q && (age_q != '1)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= CTR_RST;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      age_q   <= age_d;
    end
  end

  // Target is pre-masked so the top can OR-reduce across rows.
  assign if_hit_o = valid_q && (tag_q == if_pc_i);
  assign ex_hit_o = valid_q && (tag_q == ex_pc_i);
  assign pred_o   = if_hit_o && ((ctr_q == WT) || (ctr_q == ST));
  assign target_o = if_hit_o ? tgt_q : '0;
  assign valid_o  = valid_q;
  assign age_o    = age_q;

endmodule

// File: rtl/btb_assoc_predictor.sv
// Fully-associative branch target buffer: combinational IF lookup, EX-stage
// training with invalid-first / oldest-entry replacement.
module btb_assoc_predictor
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES     = 8,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned AGE_W       = 4,
  parameter int unsigned ALLOC_TAKEN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [PC_W-1:0] IF_PC,
  input  logic [PC_W-1:0] EX_PC,
  input  logic            EX_Branch,
  input  logic            Branch_Success,
  input  logic [PC_W-1:0] PC_des_in,
  output logic            IF_PC_hit,
  output logic            EX_PC_hit,
  output logic [PC_W-1:0] PC_des_out,
  output logic            Pred_Jump
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0] valid, if_hit, ex_hit, pred, upd, alloc, victim_oh;
  logic [PC_W-1:0]    tgt [ENTRIES];
  logic [AGE_W-1:0]   age [ENTRIES];
  logic               alloc_ok, age_inc, any_inv;
  logic [IDX_W-1:0]   inv_idx, old_idx, victim;
  logic [AGE_W-1:0]   old_age;

  assign alloc_ok = EX_Branch && !EX_PC_hit && ((ALLOC_TAKEN == 0) || Branch_Success);
  assign age_inc  = (EX_Branch && EX_PC_hit) || alloc_ok;
  assign upd      = {ENTRIES{EX_Branch}} & ex_hit;
  assign alloc    = {ENTRIES{alloc_ok}} & victim_oh;

  // Lowest invalid row wins; otherwise strictly-greater age keeps the lowest index on ties.
  always_comb begin
    any_inv   = 1'b0;
    inv_idx   = '0;
    old_idx   = '0;
    old_age   = age[0];
    victim_oh = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (!valid[i-1]) begin
        any_inv = 1'b1;
        inv_idx = IDX_W'(i - 1);
      end
    end
    for (int unsigned i = 1; i < ENTRIES; i++) begin
      if (age[i] > old_age) begin
        old_age = age[i];
        old_idx = IDX_W'(i);
      end
    end
    victim = any_inv ? inv_idx : old_idx;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      victim_oh[i] = (victim == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_row
    btb_entry #(
      .PC_W (PC_W),
      .AGE_W(AGE_W)
    ) u_entry (
      .clk_i    (clk),
      .rst_ni   (rst),
      .flush_i  (flush),
      .upd_i    (upd[g]),
      .alloc_i  (alloc[g]),
      .age_inc_i(age_inc),
      .taken_i  (Branch_Success),
      .if_pc_i  (IF_PC),
      .ex_pc_i  (EX_PC),
      .des_i    (PC_des_in),
      .valid_o  (valid[g]),
      .if_hit_o (if_hit[g]),
      .ex_hit_o (ex_hit[g]),
      .pred_o   (pred[g]),
      .target_o (tgt[g]),
      .age_o    (age[g])
    );
  end

  always_comb begin
    PC_des_out = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      PC_des_out = PC_des_out | tgt[i];
    end
  end

  assign IF_PC_hit = |if_hit;
  assign EX_PC_hit = |ex_hit;
  assign Pred_Jump = |pred;

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Scoreboard bench: two DUTs (always-allocate and taken-only allocate) share
// stimulus; an array-based reference model predicts every lookup.
module tb_btb_assoc_predictor;

  localparam int N = 8;
  localparam int AGE_MAX = 15;

  logic        clk, rst, flush, EX_Branch, Branch_Success;
  logic [31:0] IF_PC, EX_PC, PC_des_in;
  logic        if_hit0, ex_hit0, pj0, if_hit1, ex_hit1, pj1;
  logic [31:0] des0, des1;

  btb_assoc_predictor #(.ENTRIES(8), .PC_W(32), .AGE_W(4), .ALLOC_TAKEN(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .IF_PC(IF_PC), .EX_PC(EX_PC),
    .EX_Branch(EX_Branch), .Branch_Success(Branch_Success), .PC_des_in(PC_des_in),
    .IF_PC_hit(if_hit0), .EX_PC_hit(ex_hit0), .PC_des_out(des0), .Pred_Jump(pj0));

  btb_assoc_predictor #(.ENTRIES(8), .PC_W(32), .AGE_W(4), .ALLOC_TAKEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .IF_PC(IF_PC), .EX_PC(EX_PC),
    .EX_Branch(EX_Branch), .Branch_Success(Branch_Success), .PC_des_in(PC_des_in),
    .IF_PC_hit(if_hit1), .EX_PC_hit(ex_hit1), .PC_des_out(des1), .Pred_Jump(pj1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit [1:0]    if_hit;
    bit [1:0]    ex_hit;
    bit [1:0]    pj;
    logic [31:0] des [2];
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: index 0 allocates on every miss, index 1 only on taken.
  bit          mv   [2][N];
  logic [31:0] mtag [2][N];
  logic [31:0] mtgt [2][N];
  int          mctr [2][N];
  int          mage [2][N];

  function automatic int find(int m, logic [31:0] pc);
    for (int i = 0; i < N; i++) if (mv[m][i] && mtag[m][i] == pc) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) begin
        mv[m][i] = 0; mctr[m][i] = 1; mage[m][i] = 0;
      end
  endtask

  task automatic age_others(int m, int keep);
    for (int j = 0; j < N; j++)
      if (j != keep && mv[m][j] && mage[m][j] < AGE_MAX) mage[m][j]++;
  endtask

  task automatic model_update(bit fl, bit br, bit tk, logic [31:0] expc, logic [31:0] des);
    for (int m = 0; m < 2; m++) begin
      int h, v, best;
      if (fl) begin
        for (int i = 0; i < N; i++) mv[m][i] = 0;
        continue;
      end
      if (!br) continue;
      h = find(m, expc);
      if (h >= 0) begin
        mctr[m][h] = tk ? ((mctr[m][h] == 3) ? 3 : mctr[m][h] + 1)
                        : ((mctr[m][h] == 0) ? 0 : mctr[m][h] - 1);
        if (tk) mtgt[m][h] = des;
        age_others(m, h);
        mage[m][h] = 0;
      end else if (m == 0 || tk) begin
        v = -1;
        for (int i = N - 1; i >= 0; i--) if (!mv[m][i]) v = i;
        if (v < 0) begin
          best = -1;
          v = 0;
          for (int i = 0; i < N; i++)
            if (mage[m][i] > best) begin best = mage[m][i]; v = i; end
        end
        age_others(m, v);
        mv[m][v] = 1; mtag[m][v] = expc; mtgt[m][v] = des;
        mctr[m][v] = tk ? 2 : 1; mage[m][v] = 0;
      end
    end
  endtask

  task automatic push_exp(string name);
    exp_t e;
    e.name = name;
    for (int m = 0; m < 2; m++) begin
      int h;
      h = find(m, IF_PC);
      e.if_hit[m] = (h >= 0);
      e.des[m]    = (h >= 0) ? mtgt[m][h] : 32'h0;
      e.pj[m]     = (h >= 0) && (mctr[m][h] >= 2);
      e.ex_hit[m] = (find(m, EX_PC) >= 0);
    end
    q.push_back(e);
  endtask

  task automatic step(logic [31:0] ifpc, logic [31:0] expc, bit br, bit tk,
                      logic [31:0] des, bit fl, string name);
    IF_PC = ifpc; EX_PC = expc; EX_Branch = br; Branch_Success = tk;
    PC_des_in = des; flush = fl;
    push_exp(name);
    @(posedge clk);
    if (!rst) model_reset();
    else model_update(fl, br, tk, expc, des);
    #2;
  endtask

  task automatic reset_mid(logic [31:0] ifpc, logic [31:0] expc, logic [31:0] des);
    IF_PC = ifpc; EX_PC = expc; EX_Branch = 1; Branch_Success = 1;
    PC_des_in = des; flush = 0;
    #1 rst = 0;
    model_reset();
    push_exp("rst_mid");
    @(posedge clk);
    model_reset();
    #2 rst = 1;
  endtask

  task automatic check(string name, int m, bit ih, bit eh, logic [31:0] d, bit p, exp_t e);
    vectors++;
    if (ih !== e.if_hit[m] || eh !== e.ex_hit[m] || d !== e.des[m] || p !== e.pj[m]) begin
      miscompares++;
      $display("FAIL %s dut%0d: got if_hit=%b ex_hit=%b des=%h pj=%b, want if_hit=%b ex_hit=%b des=%h pj=%b",
               name, m, ih, eh, d, p, e.if_hit[m], e.ex_hit[m], e.des[m], e.pj[m]);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.name, 0, if_hit0, ex_hit0, des0, pj0, e);
        check(e.name, 1, if_hit1, ex_hit1, des1, pj1, e);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 0; flush = 0; EX_Branch = 0; Branch_Success = 0;
    IF_PC = 32'h100; EX_PC = 0; PC_des_in = 0;
    model_reset();
    @(posedge clk); #2;
    step(32'h100, 32'h0, 0, 0, 32'h0, 0, "reset_state");
    rst = 1;

    // Allocate, then lookup; no same-cycle bypass.
    step(32'h100, 32'h100, 1, 1, 32'h200, 0, "alloc_same_cycle");
    step(32'h100, 32'h100, 0, 0, 32'h0, 0, "hit_after_alloc");
    step(32'h100, 32'h100, 1, 0, 32'h999, 0, "not_taken_upd");
    step(32'h100, 32'h0, 0, 0, 32'h0, 0, "pred_after_nt");

    // Saturate to strong-taken, then hysteresis.
    for (int k = 0; k < 3; k++) step(32'h100, 32'h100, 1, 1, 32'h240, 0, "train_taken");
    step(32'h100, 32'h100, 1, 0, 32'h0, 0, "nt1");
    step(32'h100, 32'h100, 1, 0, 32'h0, 0, "nt2_still_taken");
    step(32'h100, 32'h0, 0, 0, 32'h0, 0, "nt2_result");
    step(32'h100, 32'h0, 0, 0, 32'h0, 1, "flush_clean");

    // Fill, retrain 0x10, insert 0x90 -> 0x20 evicted.
    for (int k = 1; k <= 8; k++)
      step(32'h0, 32'h10 * k, 1, 1, 32'h1000 + 32'h10 * k, 0, "fill");
    step(32'h10, 32'h10, 1, 1, 32'h1010, 0, "retrain");
    step(32'h20, 32'h90, 1, 1, 32'h1090, 0, "insert");
    for (int k = 1; k <= 9; k++) step(32'h10 * k, 32'h0, 0, 0, 32'h0, 0, "post_evict");

    // Not-taken miss: allocates only in always-allocate mode.
    step(32'h300, 32'h300, 1, 0, 32'h3000, 0, "nt_miss");
    step(32'h300, 32'h300, 0, 0, 32'h0, 0, "nt_miss_after");

    // Flush beats a same-cycle update.
    step(32'h400, 32'h400, 1, 1, 32'h4000, 1, "flush_with_br");
    step(32'h400, 32'h400, 0, 0, 32'h0, 0, "after_flush");
    step(32'h10, 32'h90, 0, 0, 32'h0, 0, "after_flush_old");
    step(32'h500, 32'h500, 1, 1, 32'h5000, 0, "alloc_pre_rst");
    reset_mid(32'h500, 32'h500, 32'h5555);
    step(32'h500, 32'h500, 0, 0, 32'h0, 0, "after_rst");

    for (int k = 0; k < 1500; k++) begin
      logic [31:0] ip, ep, d;
      bit br, tk, fl;
      ip = 32'h10 * $urandom_range(1, 16);
      ep = 32'h10 * $urandom_range(1, 16);
      d  = $urandom & 32'hFFFF_FFFC;
      br = ($urandom_range(0, 9) < 7);
      tk = $urandom_range(0, 1);
      fl = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 499) == 0) reset_mid(ip, ep, d);
      else step(ip, ep, br, tk, d, fl, "random");
    end

    for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
